// File: rtl/prefix_accum_pkg.sv
// Shared widths, limits and FSM state type for the prefix_accum16 frame accumulator.
package prefix_accum_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/SK16.sv
// SK16: 16-bit combinational Sklansky parallel-prefix adder (carry-in fixed at 0).
module SK16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] r_unused_none;
  logic [15:0] w_p0;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_gn;
  logic [15:0] w_pn;

  assign r_unused_none = '0;

  always_comb begin
    w_p0 = a ^ b;
    w_g  = a & b;
    w_p  = w_p0;
    w_gn = '0;
    w_pn = '0;
    // Each level merges bit i with the top bit of the preceding 2^l-wide block.
    for (int unsigned l = 0; l < 4; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i >> l) & 32'd1) == 32'd1) begin
          w_gn[i] = w_g[i] | (w_p[i] & w_g[((i >> l) << l) - 1]);
          w_pn[i] = w_p[i] & w_p[((i >> l) << l) - 1];
        end
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    sum  = w_p0 ^ {w_g[14:0], 1'b0};
    cout = w_g[15];
  end

endmodule

// File: rtl/prefix_accum16.sv
// Frame accumulator: sums FRAME_LEN samples through SK16 and counts carry-outs.
// Define ACCUM_SAT_EN to saturate the frame sum to 16'hFFFF after the first carry.
module prefix_accum16
  import prefix_accum_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_carries
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_carry_cnt;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [DATA_W-1:0] r_out_sum;
  logic [CNT_W-1:0]  r_out_carries;

  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_acc_next;
  logic [CNT_W-1:0]  w_cnt_next;

  SK16 u_sk16 (
    .a    (r_acc),
    .b    (in_data),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_sample_cnt == LAST_IDX);

`ifdef ACCUM_SAT_EN
  // Once forced to all-ones, every nonzero add carries again, so no sticky flag is needed.
  assign w_acc_next = w_cout ? '1 : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  assign w_cnt_next = (w_cout && (r_carry_cnt != CNT_MAX)) ? r_carry_cnt + 1'b1 : r_carry_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ACCUM: if (w_accept && w_last) w_state_next = HOLD;
      HOLD:  if (out_ready)          w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ACCUM: in_ready  = !abort;
      HOLD:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_carry_cnt   <= '0;
      r_sample_cnt  <= '0;
      r_out_sum     <= '0;
      r_out_carries <= '0;
    end else if (r_state == ACCUM) begin
      if (abort) begin
        r_acc        <= '0;
        r_carry_cnt  <= '0;
        r_sample_cnt <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_out_sum     <= w_acc_next;
          r_out_carries <= w_cnt_next;
          r_acc         <= '0;
          r_carry_cnt   <= '0;
          r_sample_cnt  <= '0;
        end else begin
          r_acc        <= w_acc_next;
          r_carry_cnt  <= w_cnt_next;
          r_sample_cnt <= r_sample_cnt + 1'b1;
        end
      end
    end
  end

  assign out_sum     = r_out_sum;
  assign out_carries = r_out_carries;

endmodule

// File: tb/tb_prefix_accum16.sv
// Self-checking bench for prefix_accum16 (FRAME_LEN=4 and FRAME_LEN=1 instances).
module tb_prefix_accum16;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v4, rdy4, ab4, ov4, or4;
  logic [15:0] d4, os4;
  logic [7:0]  oc4;

  logic        v1, rdy1, ab1, ov1, or1;
  logic [15:0] d1, os1;
  logic [7:0]  oc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prefix_accum16 #(.FRAME_LEN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .abort(ab4), .out_valid(ov4), .out_ready(or4), .out_sum(os4), .out_carries(oc4)
  );

  prefix_accum16 #(.FRAME_LEN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .abort(ab1), .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_carries(oc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [15:0] d);
    int k = 0;
    d4 = d;
    v4 = 1'b1;
    #1;
    while (!rdy4 && k < 50) begin
      tick();
      k++;
    end
    check("send4_ready", 32'(rdy4), 32'd1);
    tick();
    v4 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d);
    int k = 0;
    d1 = d;
    v1 = 1'b1;
    #1;
    while (!rdy1 && k < 50) begin
      tick();
      k++;
    end
    check("send1_ready", 32'(rdy1), 32'd1);
    tick();
    v1 = 1'b0;
  endtask

  // Reference: {carries, sum} of a frame, computed with plain 17-bit arithmetic.
  function automatic logic [23:0] frame_model(input logic [15:0] q[$]);
    logic [15:0] acc = '0;
    int          cnt = 0;
    logic [16:0] t;
    foreach (q[i]) begin
      t = {1'b0, acc} + {1'b0, q[i]};
      if (t[16]) begin
        if (cnt < 255) cnt++;
`ifdef ACCUM_SAT_EN
        acc = 16'hFFFF;
`else
        acc = t[15:0];
`endif
      end else begin
        acc = t[15:0];
      end
    end
    return {8'(cnt), acc};
  endfunction

  initial begin
    logic [15:0] q[$];
    logic [23:0] exp;
    logic [15:0] held;
    logic [15:0] exp_ffff;

    rst_n = 1'b0;
    v4 = 0; d4 = '0; ab4 = 0; or4 = 0;
    v1 = 0; d1 = '0; ab1 = 0; or1 = 0;
    tick(); tick();
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_os4", 32'(os4), 32'd0);
    check("rst_oc4", 32'(oc4), 32'd0);
    check("rst_rdy4", 32'(rdy4), 32'd1);
    check("rst_ov1", 32'(ov1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame 1,2,3,4 with out_ready held high.
    or4 = 1'b1;
    send4(16'd1); send4(16'd2); send4(16'd3);
    check("basic_ov_early", 32'(ov4), 32'd0);
    send4(16'd4);
    check("basic_ov", 32'(ov4), 32'd1);
    check("basic_rdy_hold", 32'(rdy4), 32'd0);
    check("basic_sum", 32'(os4), 32'd10);
    check("basic_carries", 32'(oc4), 32'd0);
    tick();
    check("basic_ov_drop", 32'(ov4), 32'd0);
    check("basic_rdy_back", 32'(rdy4), 32'd1);

    // All-ones frame: carries on adds 2..4.
`ifdef ACCUM_SAT_EN
    exp_ffff = 16'hFFFF;
`else
    exp_ffff = 16'hFFFC;
`endif
    repeat (4) send4(16'hFFFF);
    check("ffff_sum", 32'(os4), 32'(exp_ffff));
    check("ffff_carries", 32'(oc4), 32'd3);
    tick();

    // Backpressure: result held stable for 5 cycles.
    or4 = 1'b0;
    send4(16'd5); send4(16'd6); send4(16'd7); send4(16'd8);
    d4 = 16'h0BAD;
    v4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", 32'(ov4), 32'd1);
      check("bp_sum", 32'(os4), 32'd26);
      check("bp_rdy", 32'(rdy4), 32'd0);
      tick();
    end
    v4 = 1'b0;
    or4 = 1'b1;
    tick();
    check("bp_release_ov", 32'(ov4), 32'd0);
    check("bp_release_rdy", 32'(rdy4), 32'd1);

    // Abort wins over in_valid and discards the partial frame.
    send4(16'd7); send4(16'd9);
    d4 = 16'd5; v4 = 1'b1; ab4 = 1'b1;
    #1;
    check("abort_rdy", 32'(rdy4), 32'd0);
    tick();
    ab4 = 1'b0; v4 = 1'b0;
    repeat (4) send4(16'd1);
    check("abort_sum", 32'(os4), 32'd4);
    check("abort_carries", 32'(oc4), 32'd0);
    tick();

    // Reset mid-frame drops partial data.
    send4(16'd100); send4(16'd100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) send4(16'd2);
    check("rstmid_sum", 32'(os4), 32'd8);
    tick();

    // Reset during HOLD.
    or4 = 1'b0;
    repeat (4) send4(16'd3);
    check("rsthold_ov_pre", 32'(ov4), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rsthold_ov", 32'(ov4), 32'd0);
    check("rsthold_sum", 32'(os4), 32'd0);
    rst_n = 1'b1;
    or4 = 1'b1;
    tick();

    // FRAME_LEN=1: every sample is a frame.
    or1 = 1'b1;
    send1(16'h1234);
    check("fl1_ov_a", 32'(ov1), 32'd1);
    check("fl1_sum_a", 32'(os1), 32'h1234);
    check("fl1_car_a", 32'(oc1), 32'd0);
    tick();
    check("fl1_ov_drop", 32'(ov1), 32'd0);
    send1(16'h0001);
    check("fl1_ov_b", 32'(ov1), 32'd1);
    check("fl1_sum_b", 32'(os1), 32'h0001);
    check("fl1_car_b", 32'(oc1), 32'd0);
    tick();

    // Randomized frames with idle gaps and random backpressure.
    for (int f = 0; f < 30; f++) begin
      q = {};
      or4 = 1'b0;
      for (int s = 0; s < 4; s++) begin
        logic [15:0] x;
        x = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                        : 16'($urandom_range(0, 255));
        q.push_back(x);
        repeat ($urandom_range(0, 2)) tick();
        send4(x);
      end
      exp = frame_model(q);
      check("rnd_ov", 32'(ov4), 32'd1);
      check("rnd_sum", 32'(os4), 32'(exp[15:0]));
      check("rnd_carries", 32'(oc4), 32'(exp[23:16]));
      held = os4;
      repeat ($urandom_range(0, 3)) tick();
      check("rnd_hold_sum", 32'(os4), 32'(held));
      or4 = 1'b1;
      tick();
      check("rnd_ov_drop", 32'(ov4), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
